// File: rtl/adc_digout_emulator.sv
// Emulates the sensor's serial ADC DIGOUT lanes: one NBITS word per channel per row,
// shifted out one bit per adc_data_valid pulse after a falling edge on rst_bar_ltchd.
module adc_digout_emulator #(
    parameter int NCH   = 17,
    parameter int NBITS = 12,
    parameter int ROW_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_bar_ltchd,
    input  logic             adc_data_valid,
    input  logic [1:0]       mode,
    input  logic             msb_first,
    input  logic [NBITS-1:0] fixed_pattern,
    output logic [NCH-1:0]   digout,
    output logic             busy,
    output logic             row_done,
    output logic [ROW_W-1:0] row_cnt,
    output logic             overrun
);

    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prev;
    logic             fall;
    logic             accept;
    logic [NBITS-1:0] row_idx;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] bit_cnt;
    logic [NBITS-1:0] shreg [NCH];
    logic [NBITS-1:0] words [NCH];

    function automatic logic [NBITS-1:0] bit_rev(input logic [NBITS-1:0] v);
        logic [NBITS-1:0] r;
        r = '0;
        for (int i = 0; i < NBITS; i++) begin
            r[i] = v[NBITS-1-i];
        end
        return r;
    endfunction

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    assign fall   = prev & ~rst_bar_ltchd;
    // The row_done cycle still counts as busy, so a fall there is an overrun.
    assign accept = fall && (state == IDLE) && !row_done;
    assign busy   = (state != IDLE);

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            words[ch] = '0;
            case (mode)
                2'd0:    words[ch] = row_idx;
                2'd1:    words[ch] = row_idx + NBITS'(ch);
                2'd2:    words[ch] = fixed_pattern;
                default: words[ch] = lfsr[NBITS-1:0] ^ NBITS'(ch);
            endcase
            if (msb_first) begin
                words[ch] = bit_rev(words[ch]);
            end
        end
    end

    always_comb begin
        digout = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            digout[ch] = shreg[ch][0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT_HI;
            WAIT_HI: if (adc_data_valid) state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!adc_data_valid) begin
                    state_nxt = (bit_cnt == LAST_BIT) ? IDLE : WAIT_HI;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= 1'b1;
            row_cnt  <= '0;
            row_idx  <= '0;
            lfsr     <= LFSR_SEED;
            bit_cnt  <= '0;
            row_done <= 1'b0;
            overrun  <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                shreg[ch] <= '0;
            end
        end else begin
            prev     <= rst_bar_ltchd;
            row_done <= 1'b0;
            if (fall && !accept) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                row_idx <= row_cnt[NBITS-1:0];
                row_cnt <= row_cnt + 1'b1;
            end
            case (state)
                LOAD: begin
                    for (int ch = 0; ch < NCH; ch++) begin
                        shreg[ch] <= words[ch];
                    end
                    bit_cnt <= '0;
                    lfsr    <= lfsr_step(lfsr);
                end
                WAIT_HI: begin
                    if (adc_data_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!adc_data_valid) begin
                        for (int ch = 0; ch < NCH; ch++) begin
                            shreg[ch] <= {1'b0, shreg[ch][NBITS-1:1]};
                        end
                        if (bit_cnt == LAST_BIT) begin
                            row_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_digout_emulator.sv
// Directed/randomised bench for adc_digout_emulator with a word-level reference model.
module tb_adc_digout_emulator;

    localparam int NCH   = 17;
    localparam int NBITS = 12;
    localparam int ROW_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             rst_bar_ltchd;
    logic             adc_data_valid;
    logic [1:0]       mode;
    logic             msb_first;
    logic [NBITS-1:0] fixed_pattern;
    logic [NCH-1:0]   digout;
    logic             busy;
    logic             row_done;
    logic [ROW_W-1:0] row_cnt;
    logic             overrun;

    adc_digout_emulator #(.NCH(NCH), .NBITS(NBITS), .ROW_W(ROW_W)) dut (
        .clk(clk),
        .rst(rst),
        .rst_bar_ltchd(rst_bar_ltchd),
        .adc_data_valid(adc_data_valid),
        .mode(mode),
        .msb_first(msb_first),
        .fixed_pattern(fixed_pattern),
        .digout(digout),
        .busy(busy),
        .row_done(row_done),
        .row_cnt(row_cnt),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               m_row  = 0;
    logic [15:0]      m_lfsr = 16'hACE1;
    logic             m_ovr  = 1'b0;
    logic             m_msb  = 1'b0;
    logic [NBITS-1:0] exp_w [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [NBITS-1:0] model_word(input int md, input int ch, input int r,
                                                    input logic [15:0] lf,
                                                    input logic [NBITS-1:0] fx);
        int mod;
        mod = 1 << NBITS;
        case (md)
            0:       return NBITS'(r % mod);
            1:       return NBITS'((r + ch) % mod);
            2:       return fx;
            default: return NBITS'((int'(lf) % mod) ^ ch);
        endcase
    endfunction

    // Lane value during bit period k; zero once the word is exhausted.
    function automatic logic [NCH-1:0] exp_vec(input int k);
        logic [NCH-1:0] v;
        v = '0;
        if (k < NBITS) begin
            for (int ch = 0; ch < NCH; ch++) begin
                v[ch] = m_msb ? exp_w[ch][NBITS-1-k] : exp_w[ch][k];
            end
        end
        return v;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        adc_data_valid = 1'b0;
        rst_bar_ltchd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_row = 0;
        m_lfsr = 16'hACE1;
        m_ovr = 1'b0;
        chk({tag, "_digout"}, 64'(digout), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_row_done"}, 64'(row_done), 64'd0);
        chk({tag, "_row_cnt"}, 64'(row_cnt), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    task automatic start_row(input logic [1:0] md, input logic msb,
                             input logic [NBITS-1:0] fx, input bit hold_low);
        rst_bar_ltchd = 1'b1;
        mode = md;
        msb_first = msb;
        fixed_pattern = fx;
        @(negedge clk);
        rst_bar_ltchd = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_w[ch] = model_word(int'(md), ch, m_row, m_lfsr, fx);
        end
        m_msb = msb;
        m_row = m_row + 1;
        m_lfsr = model_lfsr_next(m_lfsr);
        @(negedge clk);
        chk("load_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("first_bit", 64'(digout), 64'(exp_vec(0)));
        chk("row_cnt_start", 64'(row_cnt), 64'(ROW_W'(m_row)));
        if (!hold_low) rst_bar_ltchd = 1'b1;
    endtask

    task automatic shift_bits(input int nb, input int hi, input int lo, input int ovr_at);
        for (int k = 0; k < nb; k++) begin
            adc_data_valid = 1'b1;
            if (k == ovr_at) begin
                rst_bar_ltchd = 1'b0;
                m_ovr = 1'b1;
            end
            for (int h = 0; h < hi; h++) begin
                @(negedge clk);
                if (k == ovr_at && h == 0) rst_bar_ltchd = 1'b1;
                chk($sformatf("bit%0d_hi", k), 64'(digout), 64'(exp_vec(k)));
                chk("busy_hi", 64'(busy), 64'd1);
            end
            adc_data_valid = 1'b0;
            for (int l = 0; l < lo; l++) begin
                @(negedge clk);
                chk($sformatf("bit%0d_lo", k), 64'(digout), 64'(exp_vec(k + 1)));
                chk("row_done", 64'(row_done), 64'(l == 0 && k == NBITS - 1));
            end
        end
    endtask

    task automatic end_row_checks(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_digout"}, 64'(digout), 64'd0);
        chk({tag, "_row_cnt"}, 64'(row_cnt), 64'(ROW_W'(m_row)));
        chk({tag, "_overrun"}, 64'(overrun), 64'(m_ovr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        mode = 2'd0;
        msb_first = 1'b0;
        fixed_pattern = '0;
        do_reset("reset");

        // Valid pulses while idle must not start anything.
        for (int i = 0; i < 3; i++) begin
            adc_data_valid = 1'b1;
            @(negedge clk);
            adc_data_valid = 1'b0;
            @(negedge clk);
            chk("idle_valid_busy", 64'(busy), 64'd0);
            chk("idle_valid_digout", 64'(digout), 64'd0);
        end

        // Mode 0, LSB first, fastest bit rate; first row keeps the strobe low throughout.
        start_row(2'd0, 1'b0, '0, 1'b1);
        shift_bits(NBITS, 1, 1, -1);
        end_row_checks("m0_row0");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_low_no_restart", 64'(busy), 64'd0);
        end
        for (int r = 1; r < 3; r++) begin
            start_row(2'd0, 1'b0, '0, 1'b0);
            shift_bits(NBITS, 1, 1, -1);
            end_row_checks("m0_row");
        end
        chk("m0_row_cnt3", 64'(row_cnt), 64'd3);

        // Mode 1, MSB first, random pulse widths.
        do_reset("reset_m1");
        for (int r = 0; r < 2; r++) begin
            start_row(2'd1, 1'b1, '0, 1'b0);
            shift_bits(NBITS, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), -1);
            end_row_checks("m1_row");
        end

        // Mode 2, fixed pattern with long valid pulses, then a random pattern.
        start_row(2'd2, 1'b0, 12'hA5C, 1'b0);
        shift_bits(NBITS, 5, 1, -1);
        end_row_checks("m2_a5c");
        start_row(2'd2, 1'($urandom_range(0, 1)), NBITS'($urandom), 1'b0);
        shift_bits(NBITS, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), -1);
        end_row_checks("m2_rand");

        // Mode 3 from the reset seed, two rows.
        do_reset("reset_m3");
        for (int r = 0; r < 2; r++) begin
            start_row(2'd3, 1'b0, '0, 1'b0);
            shift_bits(NBITS, 1, int'($urandom_range(1, 2)), -1);
            end_row_checks("m3_row");
        end

        // Fall in the row_done cycle is rejected and flagged.
        start_row(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), NBITS'($urandom), 1'b0);
        shift_bits(NBITS, 1, 1, -1);
        rst_bar_ltchd = 1'b0;
        m_ovr = 1'b1;
        @(negedge clk);
        rst_bar_ltchd = 1'b1;
        chk("done_cycle_fall_busy", 64'(busy), 64'd0);
        chk("done_cycle_fall_ovr", 64'(overrun), 64'd1);
        chk("done_cycle_fall_cnt", 64'(row_cnt), 64'(ROW_W'(m_row)));
        @(negedge clk);
        chk("done_cycle_fall_idle", 64'(busy), 64'd0);

        // Second fall after 4 bits: row completes unchanged, overrun set.
        do_reset("reset_ovr");
        start_row(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), NBITS'($urandom), 1'b0);
        shift_bits(NBITS, int'($urandom_range(1, 3)), 1, 4);
        end_row_checks("ovr_row");
        @(negedge clk);
        chk("ovr_no_extra_row", 64'(busy), 64'd0);
        chk("ovr_row_cnt", 64'(row_cnt), 64'd1);

        // Reset after 7 bits, then a fresh row starts from word 0.
        start_row(2'd0, 1'b0, '0, 1'b0);
        shift_bits(7, 1, 1, -1);
        do_reset("mid_row_rst");
        start_row(2'd0, 1'b0, '0, 1'b0);
        shift_bits(NBITS, 1, 1, -1);
        end_row_checks("after_rst_row");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
